// File: rtl/mem_access_pkg.sv
// Shared funct3 codes, FSM encoding and decode helpers for the memory-access stage.
`timescale 1ns/1ps
package mem_access_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Width of the BUSY-cycle timeout counter
  localparam int TO_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Everything needed to finish a load after EX has moved on
  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic [4:0] waddr;
  } load_ctl_t;

  // Stores only know B/H/W; loads add the unsigned B/H forms
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store)
      f3_legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Size lives in funct3[1:0] for both loads and stores
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane steering: store byte enables / replicated data and load extraction / extension.
`timescale 1ns/1ps
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the datum across all lanes, enable only the addressed ones
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Load side: pick the addressed lane and sign- or zero-extend it
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  load_data = {24'h0, ld_byte};
      F3_LHU:  load_data = {16'h0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: ALU results pass straight through, loads/stores run one
// req/ack bus transaction while holding the pipeline.
`timescale 1ns/1ps
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        ex_mem_re_i,
  input  logic        ex_mem_we_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic [31:0] ex_reg_wdata_i,
  input  logic        ex_reg_we_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_we_o,
  output logic        stall_flag_o,
  output logic        access_err_o,
  output logic        bus_timeout_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state, state_nxt;
  load_ctl_t       ctl;
  logic [TO_W-1:0] to_cnt;

  logic        is_mem, legal, issue, to_hit, busy;
  logic [2:0]  f3_sel;
  logic [1:0]  alo_sel;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;

  assign busy   = (state == S_BUSY);
  assign is_mem = ex_valid_i & (ex_mem_re_i | ex_mem_we_i);
  assign legal  = f3_legal(ex_funct3_i, ex_mem_we_i) &
                  ~misaligned(ex_funct3_i, ex_addr_i[1:0]);
  assign issue  = ~busy & is_mem & legal;
  assign to_hit = busy & ~dbus_ack_i & (to_cnt == TO_LAST);

  // While BUSY the lane logic works off the captured copy, since EX may have changed
  assign f3_sel  = busy ? ctl.funct3  : ex_funct3_i;
  assign alo_sel = busy ? ctl.addr_lo : ex_addr_i[1:0];

  mem_access_align u_align (
    .funct3     (f3_sel),
    .addr_lo    (alo_sel),
    .store_data (ex_store_data_i),
    .rdata      (dbus_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_ldata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: issue a legal mem op, leave BUSY on ack or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue) state_nxt = S_BUSY;
      S_BUSY: if (dbus_ack_i || to_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus request follows the state directly, so an async reset drops it at once
  assign dbus_req_o = busy;

  // Outputs toward ex_memwb: passthrough in IDLE, load writeback on ack
  always_comb begin
    reg_waddr_o   = ex_reg_waddr_i;
    reg_wdata_o   = ex_reg_wdata_i;
    reg_we_o      = 1'b0;
    stall_flag_o  = 1'b0;
    access_err_o  = 1'b0;
    bus_timeout_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem)    reg_we_o     = ex_reg_we_i;
          else if (legal) stall_flag_o = 1'b1;
          else            access_err_o = 1'b1;
        end
      end
      S_BUSY: begin
        reg_waddr_o = ctl.waddr;
        reg_wdata_o = al_ldata;
        if (dbus_ack_i)  reg_we_o      = ctl.is_load;
        else if (to_hit) bus_timeout_o = 1'b1;
        else             stall_flag_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the bus transaction and load control at issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'h0;
      dbus_wdata_o <= 32'h0;
      dbus_be_o    <= 4'h0;
      ctl          <= '0;
    end else if (issue) begin
      dbus_we_o    <= ex_mem_we_i;
      dbus_addr_o  <= {ex_addr_i[31:2], 2'b00};
      dbus_wdata_o <= al_wdata;
      dbus_be_o    <= al_be;
      ctl.is_load  <= ex_mem_re_i;
      ctl.funct3   <= ex_funct3_i;
      ctl.addr_lo  <= ex_addr_i[1:0];
      ctl.waddr    <= ex_reg_waddr_i;
    end
  end

  // Count BUSY cycles without ack; value k-1 during BUSY cycle k
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       to_cnt <= '0;
    else if (busy) to_cnt <= to_cnt + 1'b1;
    else           to_cnt <= '0;
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vectors plus a writeback scoreboard.
`timescale 1ns/1ps
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_re, ex_we, ex_reg_we;
  logic [2:0]  ex_f3;
  logic [31:0] ex_addr, ex_sdata, ex_reg_wdata;
  logic [4:0]  ex_reg_waddr;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_we, stall, acc_err, bus_to;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  mem_access #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_mem_re_i(ex_re), .ex_mem_we_i(ex_we),
    .ex_funct3_i(ex_f3), .ex_addr_i(ex_addr), .ex_store_data_i(ex_sdata),
    .ex_reg_waddr_i(ex_reg_waddr), .ex_reg_wdata_i(ex_reg_wdata), .ex_reg_we_i(ex_reg_we),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr),
    .dbus_wdata_o(dbus_wdata), .dbus_be_o(dbus_be),
    .dbus_ack_i(dbus_ack), .dbus_rdata_i(dbus_rdata),
    .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata), .reg_we_o(reg_we),
    .stall_flag_o(stall), .access_err_o(acc_err), .bus_timeout_o(bus_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Every writeback must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && reg_we === 1'b1) begin
      if (sb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("wb_addr", {27'h0, reg_waddr}, {27'h0, mon_e.waddr});
        chk("wb_data", reg_wdata, mon_e.wdata);
      end
    end
  end

  task automatic clr_ex();
    ex_valid = 0; ex_re = 0; ex_we = 0; ex_reg_we = 0; ex_f3 = 3'b0;
    ex_addr = 32'h0; ex_sdata = 32'h0; ex_reg_waddr = 5'h0; ex_reg_wdata = 32'h0;
  endtask

  // Present a mem op for one cycle starting just after the next rising edge
  task automatic drive_mem(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] wa);
    @(posedge clk); #1;
    ex_valid = 1; ex_re = !st; ex_we = st; ex_f3 = f3; ex_addr = a; ex_sdata = sd;
    ex_reg_waddr = wa; ex_reg_wdata = 32'hBAD0_BAD0; ex_reg_we = 1;
  endtask

  // Load table: funct3, address, bus data, expected writeback
  logic [2:0]  lt_f3 [5] = '{3'b001, 3'b100, 3'b101, 3'b010, 3'b000};
  logic [31:0] lt_a  [5] = '{32'h102, 32'h101, 32'h100, 32'h104, 32'h100};
  logic [31:0] lt_rd [5] = '{32'h8001_1234, 32'h0000_F200, 32'h1234_9ABC, 32'hDEAD_BEEF, 32'h0000_007F};
  logic [31:0] lt_ex [5] = '{32'hFFFF_8001, 32'h0000_00F2, 32'h0000_9ABC, 32'hDEAD_BEEF, 32'h0000_007F};

  initial begin
    rst = 1; dbus_ack = 0; dbus_rdata = 32'h0;
    clr_ex();
    #3;
    chk("rst_req",   {31'h0, dbus_req}, 32'd0);
    chk("rst_we",    {31'h0, dbus_we}, 32'd0);
    chk("rst_addr",  dbus_addr, 32'h0);
    chk("rst_wdata", dbus_wdata, 32'h0);
    chk("rst_be",    {28'h0, dbus_be}, 32'h0);
    chk("rst_comb",  {29'h0, reg_we, stall, acc_err | bus_to}, 32'd0);
    @(posedge clk); #1 rst = 0;

    // ALU passthrough, zero latency
    @(posedge clk); #1;
    ex_valid = 1; ex_reg_wdata = 32'h1234; ex_reg_waddr = 5'd5; ex_reg_we = 1;
    sb.push_back('{5'd5, 32'h1234});
    @(negedge clk);
    chk("alu_stall_req", {30'h0, stall, dbus_req}, 32'd0);
    @(posedge clk); #1 clr_ex();

    // LB 0x103, ack two cycles later; EX inputs churn while BUSY
    drive_mem(0, 3'b000, 32'h103, 32'h0, 5'd7);
    @(negedge clk);
    chk("lb_n_stall", {30'h0, stall, dbus_req}, 32'b10);
    @(posedge clk); #1 ex_addr = 32'hFFF0; ex_f3 = 3'b010;
    @(negedge clk);
    chk("lb_n1_req", {30'h0, stall, dbus_req}, 32'b11);
    chk("lb_addr", dbus_addr, 32'h100);
    chk("lb_we", {31'h0, dbus_we}, 32'd0);
    sb.push_back('{5'd7, 32'hFFFF_FF80});
    @(posedge clk); #1 clr_ex(); dbus_ack = 1; dbus_rdata = 32'h80FF_0000;
    @(negedge clk);
    chk("lb_ack_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1 dbus_ack = 0;
    @(negedge clk);
    chk("lb_req_drop", {31'h0, dbus_req}, 32'd0);

    // SH 0x202
    drive_mem(1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd3);
    @(posedge clk); #1 clr_ex(); dbus_ack = 1;
    @(negedge clk);
    chk("sh_addr", dbus_addr, 32'h200);
    chk("sh_be", {28'h0, dbus_be}, 32'hC);
    chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'h0, dbus_we}, 32'd1);
    chk("sh_ack", {30'h0, reg_we, stall}, 32'd0);
    @(posedge clk); #1 dbus_ack = 0;

    // Other stores
    drive_mem(1, 3'b000, 32'h301, 32'h0000_0055, 5'd4);
    @(posedge clk); #1 clr_ex(); dbus_ack = 1;
    @(negedge clk);
    chk("sb_be", {28'h0, dbus_be}, 32'h2);
    chk("sb_wdata", dbus_wdata, 32'h5555_5555);
    @(posedge clk); #1 dbus_ack = 0;
    drive_mem(1, 3'b010, 32'h304, 32'hCAFE_F00D, 5'd4);
    @(posedge clk); #1 clr_ex(); dbus_ack = 1;
    @(negedge clk);
    chk("sw_be", {28'h0, dbus_be}, 32'hF);
    chk("sw_wdata", dbus_wdata, 32'hCAFE_F00D);
    @(posedge clk); #1 dbus_ack = 0;

    // Load extension table, ack at minimum latency
    for (int i = 0; i < 5; i++) begin
      drive_mem(0, lt_f3[i], lt_a[i], 32'h0, 5'(10 + i));
      sb.push_back('{5'(10 + i), lt_ex[i]});
      @(posedge clk); #1 clr_ex(); dbus_ack = 1; dbus_rdata = lt_rd[i];
      @(negedge clk);
      chk("ld_addr", dbus_addr, {lt_a[i][31:2], 2'b00});
      @(posedge clk); #1 dbus_ack = 0;
    end

    // Misaligned and illegal funct3 encodings
    drive_mem(0, 3'b010, 32'h101, 32'h0, 5'd6);
    @(negedge clk);
    chk("lw_mis", {28'h0, acc_err, dbus_req, stall, reg_we}, 32'b1000);
    @(posedge clk); #1 clr_ex();
    @(negedge clk);
    chk("lw_mis_after", {30'h0, acc_err, dbus_req}, 32'd0);
    drive_mem(0, 3'b011, 32'h100, 32'h0, 5'd6);
    @(negedge clk);
    chk("ld_f3_011", {29'h0, acc_err, dbus_req, stall}, 32'b100);
    drive_mem(1, 3'b100, 32'h100, 32'h0, 5'd6);
    @(negedge clk);
    chk("st_f3_100", {29'h0, acc_err, dbus_req, stall}, 32'b100);
    drive_mem(1, 3'b001, 32'h103, 32'h0, 5'd6);
    @(negedge clk);
    chk("sh_mis", {29'h0, acc_err, dbus_req, stall}, 32'b100);
    @(posedge clk); #1 clr_ex();

    // LHU with no ack: timeout on BUSY cycle 255
    drive_mem(0, 3'b101, 32'h2, 32'h0, 5'd8);
    @(negedge clk);
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk); #1 clr_ex();
      @(negedge clk);
      if (k < 255) chk("to_wait", {30'h0, stall, bus_to}, 32'b10);
      else         chk("to_fire", {29'h0, stall, bus_to, reg_we}, 32'b010);
    end
    @(negedge clk);
    chk("to_idle", {30'h0, dbus_req, bus_to}, 32'd0);
    @(posedge clk); #1 dbus_ack = 1; dbus_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("to_stray", {30'h0, reg_we, stall}, 32'd0);
    @(posedge clk); #1 dbus_ack = 0;

    // Async reset mid-BUSY
    drive_mem(0, 3'b010, 32'h300, 32'h0, 5'd9);
    @(posedge clk); #1 clr_ex();
    @(negedge clk);
    chk("rb_req", {31'h0, dbus_req}, 32'd1);
    #1 rst = 1;
    #1 chk("rb_async", {30'h0, dbus_req, stall}, 32'd0);
    #1 rst = 0;
    @(posedge clk); #1 dbus_ack = 1; dbus_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("rb_late_ack", {30'h0, reg_we, dbus_req}, 32'd0);
    @(posedge clk); #1 dbus_ack = 0;

    @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
